mix_up: RTL and testbench

Single-channel digital upconverter for the transmit path, the counterpart of the receive-side downconverting mixer. It accepts baseband I/Q samples through a valid/ready handshake and holds each one for a programmable number of clocks. It mixes the held sample against an internal NCO (I·cos − Q·sin) and delivers a rounded, saturated 12-bit word per clock to the DAC.

---
 rtl/mix_up.sv | 223 ++++++++++++++++++++++
 tb/tb_mix_up.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_up.sv
// -----------------------------------------------------------------------------
// mix_up -- single-channel digital upconverter (transmit path).
//
// Takes signed 18-bit baseband I/Q samples over a valid/ready handshake, holds
// each one for max(interp,1) clocks, mixes the held value against an internal
// NCO (I*cos - Q*sin), then rounds and saturates the result into a signed
// DAC_W-bit word that is produced every clock.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous, active-high reset
//   enable     : run control for handshake, NCO and pipeline
//   phi        : unsigned phase increment per enabled clock
//   interp     : clocks per baseband sample (0 behaves as 1)
//   bb_i/bb_q  : signed baseband sample, full scale +/-2^17
//   bb_valid   : sample present
//   bb_ready   : block takes a sample this cycle (combinational)
//   dac        : signed DAC word
//   dac_valid  : dac carries mixer output
//   sat        : dac word in this cycle was clipped
//   underflow  : a sample slot found bb_valid low (cycle after the slot)
// -----------------------------------------------------------------------------
module mix_up #(
   parameter int PHASE_W = 32,
   parameter int DAC_W   = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [PHASE_W-1:0] phi,
   input  logic [7:0]         interp,
   input  logic [17:0]        bb_i,
   input  logic [17:0]        bb_q,
   input  logic               bb_valid,
   output logic               bb_ready,
   output logic [DAC_W-1:0]   dac,
   output logic               dac_valid,
   output logic               sat,
   output logic               underflow
);

   localparam real PI = 3.14159265358979323846;

   // Rounded result range is 14 bits wide (37-bit product sum >>> 23).
   localparam logic signed [13:0] DAC_MAX = 14'(2**(DAC_W-1) - 1);
   localparam logic signed [13:0] DAC_MIN = 14'(-(2**(DAC_W-1)));

   // Quarter-wave sine value round((2^17-1)*sin(2*pi*k/4096)), k in 0..1024.
   // Evaluated at elaboration with a Taylor series so the table needs no
   // external data file; the series is well past double precision on [0,pi/2].
   function automatic logic signed [17:0] qsin(input int k);
      real x;
      real term;
      real acc;
      x    = 2.0 * PI * $itor(k) / 4096.0;
      term = x;
      acc  = x;
      for (int n = 1; n < 16; n++) begin
         term = -term * x * x / $itor((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      return 18'($rtoi(acc * 131071.0 + 0.5));
   endfunction

   // 1025 entries so that the quadrant edge (index 1024) needs no special case.
   logic signed [17:0] qtab [0:1024];
   for (genvar k = 0; k <= 1024; k++) begin : g_qtab
      localparam logic signed [17:0] QV = qsin(k);
      assign qtab[k] = QV;
   end

   // ---------------------------------------------------------------- state
   logic [PHASE_W-1:0]  phase_q, phase_d;
   logic [7:0]          cnt_q, cnt_d;
   logic signed [17:0]  hold_re_q, hold_re_d;
   logic signed [17:0]  hold_im_q, hold_im_d;
   logic                uf_q, uf_d;
   // S1: LUT outputs with hold values delayed alongside
   logic signed [17:0]  cos1_q, cos1_d;
   logic signed [17:0]  sin1_q, sin1_d;
   logic signed [17:0]  re1_q, im1_q;
   // S2: products
   logic signed [35:0]  pre2_q, pre2_d;
   logic signed [35:0]  pim2_q, pim2_d;
   // S3: difference
   logic signed [36:0]  diff3_q, diff3_d;
   // S4: output word
   logic [DAC_W-1:0]    dac_q, dac_d;
   logic                sat_q, sat_d;
   // enable travels with the data: hold stage plus four pipeline stages
   logic [4:0]          vld_q, vld_d;

   logic                slot_s;
   logic [11:0]         p_s;
   logic [10:0]         ofs_s, rev_s;
   logic [10:0]         sin_idx_s, cos_idx_s;
   logic                sin_neg_s, cos_neg_s;
   logic signed [17:0]  sin_mag_s, cos_mag_s;
   logic signed [13:0]  r_s;

   assign slot_s   = enable & (cnt_q == 8'd0);
   assign bb_ready = slot_s & ~rst;

   // Slot counter, NCO phase, hold registers and underflow flag.
   always_comb begin
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      hold_re_d = hold_re_q;
      hold_im_d = hold_im_q;
      uf_d      = slot_s & ~bb_valid;
      if (!enable) begin
         // counter parked at 0 so the first enabled clock is a sample slot
         cnt_d     = 8'd0;
         hold_re_d = 18'sd0;
         hold_im_d = 18'sd0;
      end else begin
         phase_d = phase_q + phi;
         if (cnt_q == 8'd0) begin
            cnt_d = (interp == 8'd0) ? 8'd0 : interp - 8'd1;
            if (bb_valid) begin
               hold_re_d = $signed(bb_i);
               hold_im_d = $signed(bb_q);
            end else begin
               hold_re_d = 18'sd0;
               hold_im_d = 18'sd0;
            end
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   // Quarter-wave lookup: cos(p) = sin(p + 1024) gives the cosine quadrant.
   always_comb begin
      p_s   = phase_q[PHASE_W-1 -: 12];
      ofs_s = {1'b0, p_s[9:0]};
      rev_s = 11'd1024 - ofs_s;
      case (p_s[11:10])
         2'd0: begin
            sin_idx_s = ofs_s; sin_neg_s = 1'b0;
            cos_idx_s = rev_s; cos_neg_s = 1'b0;
         end
         2'd1: begin
            sin_idx_s = rev_s; sin_neg_s = 1'b0;
            cos_idx_s = ofs_s; cos_neg_s = 1'b1;
         end
         2'd2: begin
            sin_idx_s = ofs_s; sin_neg_s = 1'b1;
            cos_idx_s = rev_s; cos_neg_s = 1'b1;
         end
         default: begin
            sin_idx_s = rev_s; sin_neg_s = 1'b1;
            cos_idx_s = ofs_s; cos_neg_s = 1'b0;
         end
      endcase
      sin_mag_s = qtab[sin_idx_s];
      cos_mag_s = qtab[cos_idx_s];
      sin1_d    = sin_neg_s ? -sin_mag_s : sin_mag_s;
      cos1_d    = cos_neg_s ? -cos_mag_s : cos_mag_s;
   end

   // Multiply, subtract, round half up and saturate.
   always_comb begin
      pre2_d  = 36'(re1_q) * 36'(cos1_q);
      pim2_d  = 36'(im1_q) * 36'(sin1_q);
      diff3_d = 37'(pre2_q) - 37'(pim2_q);
      r_s     = 14'((diff3_q + 37'sd4194304) >>> 23);
      if (r_s > DAC_MAX) begin
         dac_d = DAC_MAX[DAC_W-1:0];
         sat_d = 1'b1;
      end else if (r_s < DAC_MIN) begin
         dac_d = DAC_MIN[DAC_W-1:0];
         sat_d = 1'b1;
      end else begin
         dac_d = r_s[DAC_W-1:0];
         sat_d = 1'b0;
      end
      vld_d = {vld_q[3:0], enable};
   end

   // All state registers; the pipeline shifts every clock regardless of enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q   <= '0;
         cnt_q     <= 8'd0;
         hold_re_q <= 18'sd0;
         hold_im_q <= 18'sd0;
         uf_q      <= 1'b0;
         cos1_q    <= 18'sd0;
         sin1_q    <= 18'sd0;
         re1_q     <= 18'sd0;
         im1_q     <= 18'sd0;
         pre2_q    <= 36'sd0;
         pim2_q    <= 36'sd0;
         diff3_q   <= 37'sd0;
         dac_q     <= '0;
         sat_q     <= 1'b0;
         vld_q     <= 5'd0;
      end else begin
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
         hold_re_q <= hold_re_d;
         hold_im_q <= hold_im_d;
         uf_q      <= uf_d;
         cos1_q    <= cos1_d;
         sin1_q    <= sin1_d;
         re1_q     <= hold_re_q;
         im1_q     <= hold_im_q;
         pre2_q    <= pre2_d;
         pim2_q    <= pim2_d;
         diff3_q   <= diff3_d;
         dac_q     <= dac_d;
         sat_q     <= sat_d;
         vld_q     <= vld_d;
      end
   end

   assign dac       = dac_q;
   assign sat       = sat_q;
   assign dac_valid = vld_q[4];
   assign underflow = uf_q;

endmodule

// File: tb/tb_mix_up.sv
// -----------------------------------------------------------------------------
// tb_mix_up -- self-checking bench for mix_up.
// A behavioural model (real-valued cos/sin) tracks slot counter, phase and
// hold values; each clock it pushes the expected output word into a queue that
// is popped four clocks later when the DUT presents that word. Directed steps
// add literal checks for the tone, underflow, saturation and ready spacing.
// -----------------------------------------------------------------------------
module tb_mix_up;

   localparam real PI = 3.14159265358979323846;

   typedef struct {
      logic [11:0] dac;
      logic        sat;
      logic        valid;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [31:0] phi;
   logic [7:0]  interp;
   logic [17:0] bb_i;
   logic [17:0] bb_q;
   logic        bb_valid;
   logic        bb_ready;
   logic [11:0] dac;
   logic        dac_valid;
   logic        sat;
   logic        underflow;

   int          checks;
   int          errors;

   // behavioural model state
   logic [31:0] m_phase;
   int          m_cnt;
   int          m_hi;
   int          m_hq;
   logic        exp_uf;
   logic        last_ready;
   exp_t        sb[$];

   mix_up #(.PHASE_W(32), .DAC_W(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .phi       (phi),
      .interp    (interp),
      .bb_i      (bb_i),
      .bb_q      (bb_q),
      .bb_valid  (bb_valid),
      .bb_ready  (bb_ready),
      .dac       (dac),
      .dac_valid (dac_valid),
      .sat       (sat),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint rnd(input real x);
      if (x >= 0.0) return longint'($rtoi(x + 0.5));
      else          return -longint'($rtoi(0.5 - x));
   endfunction

   // Expected DAC word for one hold/phase pair.
   function automatic exp_t mix_word(input int hi, input int hq, input int p, input logic v);
      exp_t   e;
      real    ang;
      longint c, s, acc, r;
      ang = 2.0 * PI * $itor(p) / 4096.0;
      c   = rnd(131071.0 * $cos(ang));
      s   = rnd(131071.0 * $sin(ang));
      acc = longint'(hi) * c - longint'(hq) * s;
      r   = (acc + 64'sd4194304) >>> 23;
      if (r > 2047) begin
         e.dac = 12'h7FF; e.sat = 1'b1;
      end else if (r < -2048) begin
         e.dac = 12'h800; e.sat = 1'b1;
      end else begin
         e.dac = 12'(r);  e.sat = 1'b0;
      end
      e.valid = v;
      return e;
   endfunction

   task automatic model_reset();
      exp_t z;
      m_phase = 32'd0;
      m_cnt   = 0;
      m_hi    = 0;
      m_hq    = 0;
      z.dac = 12'd0; z.sat = 1'b0; z.valid = 1'b0;
      sb.delete();
      for (int i = 0; i < 4; i++) sb.push_back(z);
   endtask

   // One clock: check ready, advance model at the edge, compare at negedge.
   task automatic step();
      logic slot;
      exp_t e;
      #1;
      slot       = enable && (m_cnt == 0);
      last_ready = bb_ready;
      chk("bb_ready", 32'(bb_ready), 32'(slot));
      @(posedge clk);
      if (enable) begin
         m_phase = m_phase + phi;
         if (m_cnt == 0) m_cnt = (interp == 8'd0) ? 0 : int'(interp) - 1;
         else            m_cnt = m_cnt - 1;
         if (slot) begin
            if (bb_valid) begin
               m_hi = int'($signed(bb_i));
               m_hq = int'($signed(bb_q));
            end else begin
               m_hi = 0;
               m_hq = 0;
            end
         end
      end else begin
         m_cnt = 0;
         m_hi  = 0;
         m_hq  = 0;
      end
      exp_uf = slot && !bb_valid;
      sb.push_back(mix_word(m_hi, m_hq, int'(m_phase[31:20]), enable));
      @(negedge clk);
      e = sb.pop_front();
      chk("dac",       32'(dac),       32'(e.dac));
      chk("sat",       32'(sat),       32'(e.sat));
      chk("dac_valid", 32'(dac_valid), 32'(e.valid));
      chk("underflow", 32'(underflow), 32'(exp_uf));
   endtask

   // Asynchronous reset between edges, outputs checked before any clock edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_dac",       32'(dac),       32'd0);
      chk("rst_dac_valid", 32'(dac_valid), 32'd0);
      chk("rst_sat",       32'(sat),       32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_bb_ready",  32'(bb_ready),  32'd0);
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   logic [11:0] tone [0:3];
   logic [23:0] rdy_vec;

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; enable = 1'b0; phi = 32'd0; interp = 8'd1;
      bb_i = 18'd0; bb_q = 18'd0; bb_valid = 1'b0;
      tone[0] = 12'h000; tone[1] = 12'hC00; tone[2] = 12'h000; tone[3] = 12'h400;

      // reset and idle
      do_reset();
      for (int k = 0; k < 8; k++) step();

      // quarter-rate tone
      phi = 32'h4000_0000; interp = 8'd1; bb_i = 18'd65536; bb_q = 18'd0;
      bb_valid = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 4) chk("tone_first_valid", 32'(dac_valid), 32'd0);
         if (k >= 5) begin
            chk("tone_word",  32'(dac), 32'(tone[(k - 5) % 4]));
            chk("tone_sat",   32'(sat), 32'd0);
         end
      end

      // enable gap mid-tone, then tone continues from the held phase
      enable = 1'b0;
      for (int k = 0; k < 10; k++) step();
      enable = 1'b1;
      for (int k = 0; k < 10; k++) step();

      // asynchronous reset mid-tone, then idle stays idle
      do_reset();
      for (int k = 0; k < 6; k++) step();

      // interpolation by 4, switched to 2 mid-run
      phi = 32'h0123_4567; interp = 8'd4; bb_valid = 1'b1; enable = 1'b1;
      rdy_vec = 24'd0;
      for (int k = 1; k <= 24; k++) begin
         if (k == 15) interp = 8'd2;
         bb_i = 18'($urandom); bb_q = 18'($urandom);
         step();
         rdy_vec[k-1] = last_ready;
      end
      chk("ready_pattern", 32'(rdy_vec), 32'h0055_1111);

      // underflow at the third slot
      do_reset();
      phi = 32'd0; interp = 8'd4; bb_i = 18'd65536; bb_q = 18'd0; enable = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         bb_valid = (k != 9);
         step();
         if (k == 9)  chk("uf_pulse", 32'(underflow), 32'd1);
         if (k == 10) chk("uf_clear", 32'(underflow), 32'd0);
         if (k == 12) chk("uf_before", 32'(dac), 32'h400);
         if (k >= 13 && k <= 16) chk("uf_zero", 32'(dac), 32'd0);
         if (k == 17) chk("uf_resume", 32'(dac), 32'h400);
      end

      // positive saturation at phase index 512
      do_reset();
      phi = 32'd512 << 20; interp = 8'd1; bb_i = 18'h1FFFF; bb_q = 18'h20000;
      bb_valid = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 5; k++) step();
      chk("sat_pos_dac", 32'(dac), 32'h7FF);
      chk("sat_pos_flag", 32'(sat), 32'd1);

      // negative full scale at phase 0 just fits
      do_reset();
      phi = 32'd0; bb_i = 18'h20000; bb_q = 18'd0; bb_valid = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 5; k++) step();
      chk("neg_fs_dac", 32'(dac), 32'h800);
      chk("neg_fs_sat", 32'(sat), 32'd0);

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         enable   = ($urandom_range(0, 9) != 0);
         bb_valid = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 15) == 0) interp = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) phi = $urandom;
         bb_i = 18'($urandom); bb_q = 18'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
